// File: rtl/pcpi_issue_ctrl.sv
// PCPI issue controller: broadcasts one core instruction to two PCPI responders and returns a result or trap.
// Optional watchdog enabled by defining PCPI_TIMEOUT_EN.
module pcpi_issue_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_insn,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_wr,
  output logic [31:0] resp_rd,
  output logic        resp_trap,
  output logic        pcpi_valid,
  output logic [31:0] pcpi_insn,
  output logic [31:0] pcpi_rs1,
  output logic [31:0] pcpi_rs2,
  input  logic        pcpi0_wr,
  input  logic        pcpi0_wait,
  input  logic        pcpi0_ready,
  input  logic [31:0] pcpi0_rd,
  input  logic        pcpi1_wr,
  input  logic        pcpi1_wait,
  input  logic        pcpi1_ready,
  input  logic [31:0] pcpi1_rd,
  output logic        busy
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t state, state_nxt;

  logic            req_ready_nxt;
  logic            resp_valid_nxt;
  logic            resp_wr_nxt;
  logic [XLEN-1:0] resp_rd_nxt;
  logic            resp_trap_nxt;
  logic            pcpi_valid_nxt;
  logic [XLEN-1:0] pcpi_insn_nxt;
  logic [XLEN-1:0] pcpi_rs1_nxt;
  logic [XLEN-1:0] pcpi_rs2_nxt;
  logic            busy_nxt;

`ifdef PCPI_TIMEOUT_EN
  logic [CNT_W-1:0] cnt, cnt_nxt;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
`else
  logic unused_timeout;
  assign unused_timeout = ^{CNT_W'(TIMEOUT_CYCLES), pcpi0_wait, pcpi1_wait};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state and next-output decode
  always_comb begin
    state_nxt      = state;
    resp_valid_nxt = resp_valid;
    resp_wr_nxt    = resp_wr;
    resp_rd_nxt    = resp_rd;
    resp_trap_nxt  = resp_trap;
    pcpi_valid_nxt = pcpi_valid;
    pcpi_insn_nxt  = pcpi_insn;
    pcpi_rs1_nxt   = pcpi_rs1;
    pcpi_rs2_nxt   = pcpi_rs2;
`ifdef PCPI_TIMEOUT_EN
    cnt_nxt        = cnt;
`endif
    case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          pcpi_insn_nxt  = req_insn;
          pcpi_rs1_nxt   = req_rs1;
          pcpi_rs2_nxt   = req_rs2;
          pcpi_valid_nxt = 1'b1;
`ifdef PCPI_TIMEOUT_EN
          cnt_nxt        = '0;
`endif
          state_nxt      = ISSUE;
        end
      end
      ISSUE: begin
        // Responder 0 has priority when both claim the same cycle
        if (pcpi0_ready) begin
          resp_wr_nxt    = pcpi0_wr;
          resp_rd_nxt    = pcpi0_wr ? pcpi0_rd : '0;
          resp_trap_nxt  = 1'b0;
          resp_valid_nxt = 1'b1;
          pcpi_valid_nxt = 1'b0;
          state_nxt      = RESP;
        end else if (pcpi1_ready) begin
          resp_wr_nxt    = pcpi1_wr;
          resp_rd_nxt    = pcpi1_wr ? pcpi1_rd : '0;
          resp_trap_nxt  = 1'b0;
          resp_valid_nxt = 1'b1;
          pcpi_valid_nxt = 1'b0;
          state_nxt      = RESP;
        end
`ifdef PCPI_TIMEOUT_EN
        else if (pcpi0_wait || pcpi1_wait) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          resp_wr_nxt    = 1'b0;
          resp_rd_nxt    = '0;
          resp_trap_nxt  = 1'b1;
          resp_valid_nxt = 1'b1;
          pcpi_valid_nxt = 1'b0;
          state_nxt      = RESP;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
`endif
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_nxt = 1'b0;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    req_ready_nxt = (state_nxt == IDLE);
    busy_nxt      = (state_nxt != IDLE);
  end

  // Registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_wr    <= 1'b0;
      resp_rd    <= '0;
      resp_trap  <= 1'b0;
      pcpi_valid <= 1'b0;
      pcpi_insn  <= '0;
      pcpi_rs1   <= '0;
      pcpi_rs2   <= '0;
      busy       <= 1'b0;
    end else begin
      req_ready  <= req_ready_nxt;
      resp_valid <= resp_valid_nxt;
      resp_wr    <= resp_wr_nxt;
      resp_rd    <= resp_rd_nxt;
      resp_trap  <= resp_trap_nxt;
      pcpi_valid <= pcpi_valid_nxt;
      pcpi_insn  <= pcpi_insn_nxt;
      pcpi_rs1   <= pcpi_rs1_nxt;
      pcpi_rs2   <= pcpi_rs2_nxt;
      busy       <= busy_nxt;
    end
  end

`ifdef PCPI_TIMEOUT_EN
  // Watchdog counter
  always_ff @(posedge clk) begin
    if (!resetn) cnt <= '0;
    else         cnt <= cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Directed self-checking bench for pcpi_issue_ctrl; inputs driven and outputs sampled on the falling edge.
module tb_pcpi_issue_ctrl;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [31:0] req_insn, req_rs1, req_rs2;
  logic        resp_valid, resp_ready, resp_wr, resp_trap;
  logic [31:0] resp_rd;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn, pcpi_rs1, pcpi_rs2;
  logic        pcpi0_wr, pcpi0_wait, pcpi0_ready;
  logic [31:0] pcpi0_rd;
  logic        pcpi1_wr, pcpi1_wait, pcpi1_ready;
  logic [31:0] pcpi1_rd;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  pcpi_issue_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_insn(req_insn), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_wr(resp_wr), .resp_rd(resp_rd), .resp_trap(resp_trap),
    .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2),
    .pcpi0_wr(pcpi0_wr), .pcpi0_wait(pcpi0_wait),
    .pcpi0_ready(pcpi0_ready), .pcpi0_rd(pcpi0_rd),
    .pcpi1_wr(pcpi1_wr), .pcpi1_wait(pcpi1_wait),
    .pcpi1_ready(pcpi1_ready), .pcpi1_rd(pcpi1_rd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_resp_inputs();
    pcpi0_wr = 0; pcpi0_wait = 0; pcpi0_ready = 0; pcpi0_rd = '0;
    pcpi1_wr = 0; pcpi1_wait = 0; pcpi1_ready = 0; pcpi1_rd = '0;
  endtask

  // Offer one request; returns just after the accepting edge
  task automatic issue(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2);
    req_valid = 1; req_insn = insn; req_rs1 = rs1; req_rs2 = rs2;
    step(1);
    req_valid = 0;
  endtask

  task automatic handshake();
    resp_ready = 1;
    step(1);
    resp_ready = 0;
  endtask

  task automatic test_reset();
    resetn = 0;
    step(2);
    n_checks++; if ({req_ready, resp_valid, resp_wr, resp_trap, pcpi_valid, busy} !== 6'b0)
      $display("FAIL reset_ctrl: got %b want 000000", {req_ready, resp_valid, resp_wr, resp_trap, pcpi_valid, busy}); else n_pass++;
    n_checks++; if ({resp_rd, pcpi_insn, pcpi_rs1, pcpi_rs2} !== 128'd0)
      $display("FAIL reset_data: got %h want 0", {resp_rd, pcpi_insn, pcpi_rs1, pcpi_rs2}); else n_pass++;
    resetn = 1;
    step(1);
    n_checks++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_mul();
    issue(32'h02B50533, 32'd6, 32'd7);
    n_checks++; if ({pcpi_valid, busy, req_ready} !== 3'b110)
      $display("FAIL mul_issue_ctrl: got %b want 110", {pcpi_valid, busy, req_ready}); else n_pass++;
    n_checks++; if ({pcpi_insn, pcpi_rs1, pcpi_rs2} !== {32'h02B50533, 32'd6, 32'd7})
      $display("FAIL mul_operands: got %h %h %h want 02b50533 6 7", pcpi_insn, pcpi_rs1, pcpi_rs2); else n_pass++;
    step(2);
    pcpi0_wait = 1;
    step(32);
    n_checks++; if ({pcpi_valid, resp_valid} !== 2'b10)
      $display("FAIL mul_wait_hold: got %b want 10", {pcpi_valid, resp_valid}); else n_pass++;
    n_checks++; if (pcpi_insn !== 32'h02B50533) $display("FAIL mul_insn_frozen: got %h want 02b50533", pcpi_insn); else n_pass++;
    pcpi0_wait = 0; pcpi0_ready = 1; pcpi0_wr = 1; pcpi0_rd = 32'd42;
    step(1);
    clear_resp_inputs();
    n_checks++; if ({resp_valid, resp_wr, resp_trap, pcpi_valid} !== 4'b1100)
      $display("FAIL mul_resp_flags: got %b want 1100", {resp_valid, resp_wr, resp_trap, pcpi_valid}); else n_pass++;
    n_checks++; if (resp_rd !== 32'd42) $display("FAIL mul_resp_rd: got %0d want 42", resp_rd); else n_pass++;
    handshake();
    n_checks++; if ({resp_valid, req_ready, busy} !== 3'b010)
      $display("FAIL mul_done: got %b want 010", {resp_valid, req_ready, busy}); else n_pass++;
  endtask

  task automatic test_long_div();
    issue(32'h02C5C5B3, 32'd100, 32'd3);
    pcpi1_wait = 1;
    step(100);
    n_checks++; if ({pcpi_valid, resp_valid} !== 2'b10)
      $display("FAIL div_wait_hold: got %b want 10", {pcpi_valid, resp_valid}); else n_pass++;
    pcpi1_wait = 0; pcpi1_ready = 1; pcpi1_wr = 1; pcpi1_rd = 32'hFFFFFFFF;
    step(1);
    clear_resp_inputs();
    n_checks++; if ({resp_valid, resp_wr, resp_trap} !== 3'b110)
      $display("FAIL div_resp_flags: got %b want 110", {resp_valid, resp_wr, resp_trap}); else n_pass++;
    n_checks++; if (resp_rd !== 32'hFFFFFFFF) $display("FAIL div_resp_rd: got %h want ffffffff", resp_rd); else n_pass++;
    handshake();
  endtask

  task automatic test_both_ready();
    issue(32'h0000_0033, 32'd1, 32'd2);
    step(1);
    pcpi0_ready = 1; pcpi0_wr = 1; pcpi0_rd = 32'h11;
    pcpi1_ready = 1; pcpi1_wr = 1; pcpi1_rd = 32'h22;
    step(1);
    clear_resp_inputs();
    n_checks++; if (resp_rd !== 32'h11) $display("FAIL both_ready_rd: got %h want 11", resp_rd); else n_pass++;
    n_checks++; if ({resp_valid, resp_wr} !== 2'b11) $display("FAIL both_ready_flags: got %b want 11", {resp_valid, resp_wr}); else n_pass++;
    handshake();
  endtask

  task automatic test_no_write();
    issue(32'h0000_0B0B, 32'd5, 32'd5);
    pcpi1_ready = 1; pcpi1_wr = 0; pcpi1_rd = 32'h55;
    step(1);
    clear_resp_inputs();
    n_checks++; if ({resp_valid, resp_wr, resp_trap, pcpi_valid} !== 4'b1000)
      $display("FAIL nowr_flags: got %b want 1000", {resp_valid, resp_wr, resp_trap, pcpi_valid}); else n_pass++;
    n_checks++; if (resp_rd !== 32'd0) $display("FAIL nowr_rd: got %h want 0", resp_rd); else n_pass++;
    handshake();
  endtask

  task automatic test_backpressure();
    issue(32'h0000_0A0A, 32'd8, 32'd9);
    pcpi0_ready = 1; pcpi0_wr = 1; pcpi0_rd = 32'h77;
    step(1);
    clear_resp_inputs();
    req_valid = 1; req_insn = 32'h0000_1111; req_rs1 = 32'd3; req_rs2 = 32'd4;
    for (int i = 0; i < 5; i++) begin
      step(1);
      n_checks++; if ({resp_valid, resp_wr, resp_trap, req_ready, pcpi_valid} !== 5'b11000 || resp_rd !== 32'h77)
        $display("FAIL bp_hold_%0d: got flags %b rd %h want 11000 rd 77", i,
                 {resp_valid, resp_wr, resp_trap, req_ready, pcpi_valid}, resp_rd); else n_pass++;
    end
    handshake();
    n_checks++; if ({resp_valid, req_ready, pcpi_valid} !== 3'b010)
      $display("FAIL bp_after_hs: got %b want 010", {resp_valid, req_ready, pcpi_valid}); else n_pass++;
    step(1);
    req_valid = 0;
    n_checks++; if ({pcpi_valid, req_ready} !== 2'b10 || pcpi_insn !== 32'h0000_1111)
      $display("FAIL bp_next_accept: got %b insn %h want 10 insn 00001111", {pcpi_valid, req_ready}, pcpi_insn); else n_pass++;
    pcpi0_ready = 1; pcpi0_wr = 1; pcpi0_rd = 32'h33;
    step(1);
    clear_resp_inputs();
    n_checks++; if (resp_rd !== 32'h33) $display("FAIL bp_second_rd: got %h want 33", resp_rd); else n_pass++;
    handshake();
  endtask

  task automatic test_timeout();
    issue(32'hDEAD_BEEF, 32'd0, 32'd0);
`ifdef PCPI_TIMEOUT_EN
    step(15);
    n_checks++; if ({resp_valid, pcpi_valid} !== 2'b01)
      $display("FAIL to_before: got %b want 01", {resp_valid, pcpi_valid}); else n_pass++;
    step(1);
    n_checks++; if ({resp_valid, resp_trap, resp_wr, pcpi_valid} !== 4'b1100)
      $display("FAIL to_trap_flags: got %b want 1100", {resp_valid, resp_trap, resp_wr, pcpi_valid}); else n_pass++;
    n_checks++; if (resp_rd !== 32'd0) $display("FAIL to_trap_rd: got %h want 0", resp_rd); else n_pass++;
    handshake();
    n_checks++; if ({resp_valid, req_ready} !== 2'b01)
      $display("FAIL to_done: got %b want 01", {resp_valid, req_ready}); else n_pass++;
`else
    step(1000);
    n_checks++; if ({resp_valid, resp_trap, pcpi_valid, busy} !== 4'b0011)
      $display("FAIL no_to_stuck: got %b want 0011", {resp_valid, resp_trap, pcpi_valid, busy}); else n_pass++;
    resetn = 0;
    step(1);
    resetn = 1;
    step(1);
    n_checks++; if ({req_ready, pcpi_valid} !== 2'b10)
      $display("FAIL no_to_recover: got %b want 10", {req_ready, pcpi_valid}); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid();
    issue(32'h0000_5555, 32'd1, 32'd1);
    step(3);
    resetn = 0;
    step(1);
    n_checks++; if ({pcpi_valid, resp_valid, req_ready, busy} !== 4'b0000)
      $display("FAIL rst_mid_ctrl: got %b want 0000", {pcpi_valid, resp_valid, req_ready, busy}); else n_pass++;
    resetn = 1;
    pcpi0_ready = 1; pcpi0_wr = 1; pcpi0_rd = 32'd9;
    for (int i = 0; i < 3; i++) begin
      step(1);
      n_checks++; if ({resp_valid, pcpi_valid} !== 2'b00)
        $display("FAIL rst_mid_ignore_%0d: got %b want 00", i, {resp_valid, pcpi_valid}); else n_pass++;
    end
    clear_resp_inputs();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  initial begin
    resetn = 0; req_valid = 0; req_insn = '0; req_rs1 = '0; req_rs2 = '0;
    resp_ready = 0;
    clear_resp_inputs();
    test_reset();
    test_mul();
    test_long_div();
    test_both_ready();
    test_no_write();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
